// File: rtl/fir_ctrl_pkg.sv
// Shared constants and state encoding for the FIR MAC control path.
package fir_ctrl_pkg;
  localparam int NTAPS   = 32;
  localparam int MAC_LAT = 2;
  localparam int ADDR_W  = $clog2(NTAPS);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/fir_ctrl_dly.sv
// Resettable fixed-depth shift register used to align control strobes.
module fir_ctrl_dly #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage_r [DEPTH];

  // shift chain, cleared by synchronous reset so aborted work never emerges
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[DEPTH-1];
endmodule

// File: rtl/fir_mac_sequencer.sv
// Address/strobe sequencer for a single-MAC FIR: clears the sample buffer,
// then walks NTAPS taps per accepted sample and flags the finished output.
module fir_mac_sequencer
  import fir_ctrl_pkg::state_t;
  import fir_ctrl_pkg::ST_CLEAR;
  import fir_ctrl_pkg::ST_IDLE;
  import fir_ctrl_pkg::ST_RUN;
  import fir_ctrl_pkg::ST_DRAIN;
#(
  parameter int NTAPS   = fir_ctrl_pkg::NTAPS,
  parameter int MAC_LAT = fir_ctrl_pkg::MAC_LAT,
  localparam int AW     = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          smp_we,
  output logic          smp_wzero,
  output logic [AW-1:0] smp_waddr,
  output logic [AW-1:0] smp_raddr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          out_valid,
  output logic          overrun
);
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);

  state_t        state_r;
  state_t        state_nxt;
  logic [AW-1:0] k_r;
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] base_r;
  logic          overrun_r;
  logic          run_s;
  logic          hs_s;
  logic          run_last_s;
  logic          drain_done_s;
  logic [1:0]    mac_dly_s;

  assign run_s      = (state_r == ST_RUN);
  assign in_ready   = rst & (state_r == ST_IDLE);
  assign hs_s       = in_valid & in_ready;
  assign run_last_s = run_s & (k_r == K_LAST);

  // one-cycle delay lines up mac_en/mac_clr with the 1-cycle read data
  fir_ctrl_dly #(.WIDTH(2), .DEPTH(1)) u_mac_dly (
    .clk (clk),
    .rst (rst),
    .d   ({run_s, run_s & (k_r == {AW{1'b0}})}),
    .q   (mac_dly_s)
  );

  // last-tap marker delayed through DRAIN; its arrival ends DRAIN
  fir_ctrl_dly #(.WIDTH(1), .DEPTH(1 + MAC_LAT)) u_drain_dly (
    .clk (clk),
    .rst (rst),
    .d   (run_last_s),
    .q   (drain_done_s)
  );

  // next-state selection
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_CLEAR: if (k_r == K_LAST) state_nxt = ST_IDLE;  else state_nxt = ST_CLEAR;
      ST_IDLE:  if (hs_s)          state_nxt = ST_RUN;   else state_nxt = ST_IDLE;
      ST_RUN:   if (run_last_s)    state_nxt = ST_DRAIN; else state_nxt = ST_RUN;
      ST_DRAIN: if (drain_done_s)  state_nxt = ST_IDLE;  else state_nxt = ST_DRAIN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // state, counters, write pointer and sticky overrun flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_CLEAR;
      k_r       <= {AW{1'b0}};
      wptr_r    <= {AW{1'b0}};
      base_r    <= {AW{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      // power-of-two length: k wraps to 0 on its own after the last tap
      if ((state_r == ST_CLEAR) || run_s) k_r <= k_r + AW'(1);
      else                                k_r <= {AW{1'b0}};
      if (hs_s) base_r <= wptr_r;
      else      base_r <= base_r;
      if (out_valid) wptr_r <= wptr_r + AW'(1);
      else           wptr_r <= wptr_r;
      if (in_valid && !in_ready) overrun_r <= 1'b1;
      else                       overrun_r <= overrun_r;
    end
  end

  // strobes are forced low while reset is held so the CLEAR state is silent
  always_comb begin
    smp_we    = rst & ((state_r == ST_CLEAR) | hs_s);
    smp_wzero = rst & (state_r == ST_CLEAR);
    if (state_r == ST_CLEAR) smp_waddr = k_r;
    else                     smp_waddr = wptr_r;
    smp_raddr = base_r - k_r;
    coef_addr = k_r;
    mac_en    = mac_dly_s[1];
    mac_clr   = mac_dly_s[0];
    out_valid = drain_done_s & (state_r == ST_DRAIN);
    overrun   = overrun_r;
  end
endmodule
